multicycle_control: RTL

Finite-state sequencer that drives a multi-cycle variant of the MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut registers) from the IR opcode/funct fields. It replaces the single-cycle combinational `control` decode with a Moore/Mealy FSM. The FSM issues per-cycle enables for PC, IR, register file and memory, and waits on a memory ready handshake. It also counts retired instructions and flags illegal opcodes.

---
 rtl/multicycle_control.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencer for a multi-cycle MIPS datapath with shared instruction/data
//   memory. A two-process FSM walks each instruction through fetch, decode,
//   execute and write-back. In each state it drives the datapath enables
//   and mux selects, and it waits on mem_ready during memory accesses.
//   It also counts retired instructions and flags unsupported opcodes.
//
//   Ports
//     clock, reset        rising-edge clock, synchronous active-high reset
//     opcode, funct       IR[31:26], IR[5:0]
//     mem_ready           memory finishes the current access this cycle
//     pc_write*, pc_source        PC load enables and next-PC source select
//     i_or_d, mem_read, mem_write memory address select and requests
//     ir_write, reg_write, reg_dst, mem_to_reg  IR and register-file write
//     alu_src_a, alu_src_b, alu_op              ALU operand and op selects
//     state               current FSM state, for debug
//     instr_done          pulse on the last cycle of every instruction
//     illegal_op          pulse in DECODE on an unsupported opcode
//     instr_count         retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_write_cond_ne,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_LUI_WB    = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_FETCH;
            instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (instr_done)
                instr_count <= instr_count + 1'b1;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next           = r_state;
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_write_cond_ne = 1'b0;
        pc_source        = 2'd0;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        reg_write        = 1'b0;
        reg_dst          = 2'd0;
        mem_to_reg       = 2'd0;
        alu_src_a        = 1'b0;
        alu_src_b        = 3'd0;
        alu_op           = 3'd0;
        instr_done       = 1'b0;
        illegal_op       = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed every cycle. The PC and IR load only
                // when the memory returns the instruction.
                mem_read  = 1'b1;
                alu_src_b = 3'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b = 3'd3;
                case (opcode)
                    6'd0:                 w_next = (funct == 6'd8) ? S_JR : S_R_EXEC;
                    6'd35, 6'd43:         w_next = S_MEM_ADDR;
                    6'd4, 6'd5:           w_next = S_BRANCH;
                    6'd8, 6'd10,
                    6'd12, 6'd13, 6'd14:  w_next = S_I_EXEC;
                    6'd15:                w_next = S_LUI_WB;
                    6'd2:                 w_next = S_JUMP;
                    6'd3:                 w_next = S_JAL;
                    default: begin
                        // Unsupported opcode retires as a nop.
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'd2;
                w_next    = (opcode == 6'd43) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'd2;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = 3'd1;
                pc_source        = 2'd1;
                pc_write_cond    = (opcode == 6'd4);
                pc_write_cond_ne = (opcode == 6'd5);
                instr_done       = 1'b1;
                w_next           = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                // addi/slti sign-extend; andi/ori/xori zero-extend.
                alu_src_b = (opcode == 6'd8 || opcode == 6'd10) ? 3'd2 : 3'd4;
                case (opcode)
                    6'd10:   alu_op = 3'd6;
                    6'd12:   alu_op = 3'd4;
                    6'd13:   alu_op = 3'd3;
                    6'd14:   alu_op = 3'd5;
                    default: alu_op = 3'd0;
                endcase
                w_next = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_LUI_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd3;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                // PC already holds the return address (incremented in FETCH).
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                reg_write  = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'd3;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset cuts every write and pulse, including mid-instruction.
        if (reset) begin
            pc_write         = 1'b0;
            pc_write_cond    = 1'b0;
            pc_write_cond_ne = 1'b0;
            mem_read         = 1'b0;
            mem_write        = 1'b0;
            ir_write         = 1'b0;
            reg_write        = 1'b0;
            instr_done       = 1'b0;
            illegal_op       = 1'b0;
        end
    end

endmodule
